rr_priority_arbiter: RTL and testbench
======================================

// Module: rr_priority_arbiter
// PURPOSE
//   Parametrised, registered N-request arbiter; the sequential successor of the 4x2 priority encoder.
//   Selects one requester, holds the grant until it is released, and reports a one-hot grant, a binary index and a valid flag.
//   Supports fixed priority (highest index wins, same as the 4x2 encoder) or round-robin, plus an optional hold timeout.
//   Sits between N request sources and one shared resource (bus, memory port, output channel).
// PARAMETERS
//   N        4   number of requesters, >= 2
//   W        $clog2(N)   width of the binary grant index
//   MODE     0   0 = fixed priority (req[N-1] highest), 1 = round-robin
//   MAX_HOLD 0   cycles a grant may be held before forced release; 0 = unlimited
// PORTS
//   clk      in   1   single clock; all state updates on the rising edge
//   rst      in   1   synchronous, active-high reset
//   x        in   N   request vector; one bit per requester, level-sensitive
//   gnt      out  N   one-hot grant, registered
//   y        out  W   binary index of the granted requester, registered
//   valid    out  1   1 while a grant is held
// BEHAVIOUR
//   - Reset (rst=1 at an edge): valid=0, gnt=0, y=0, state=IDLE, rr pointer=0, hold counter=0.
//     Reset overrides everything, including mid-grant: the grant drops at that edge.
//   - States and transitions:
//     IDLE: x==0 -> stay.
//     IDLE: x!=0 -> GRANT. At the edge, load gnt, y and valid=1.
//     Latency from request to grant is 1 clock.
//   - GRANT: the grant is held while x[y]=1, and while the hold counter < MAX_HOLD when MAX_HOLD>0.
//   - Release happens when x[y] falls, or when the timeout hits.
//     Release with other requests pending: re-arbitrate in the same cycle and go directly to the new grant.
//     No idle bubble; valid stays 1.
//     Release with nothing pending: -> IDLE. valid=0, gnt=0, y holds its last value.
//   - Timeout: the hold counter counts cycles in GRANT and clears on every new grant.
//     When the count reaches MAX_HOLD-1 with x[y] still 1, the grant is forcibly released.
//     The timed-out requester is excluded from that re-arbitration only.
//     If it is the sole requester, it is re-granted the cycle after next (one IDLE cycle).
//   - Fixed mode: the winner is the highest set index of the candidate vector.
//   - Round-robin mode: the winner is the lowest set index at or above ptr; otherwise the lowest set index overall (wrap).
//     On every grant, ptr <= granted+1 mod N. Index N-1 wraps to 0.
//   - Candidate vector: x with the just-released or timed-out bit masked for that cycle.
//   - A request dropping and rising again in the same cycle is not visible; level sampling only.
//   - Outputs never carry X. y is always a valid index; gnt is one-hot or zero; gnt!=0 iff valid.
// STRUCTURE
//   - Shared package: state encoding (IDLE, GRANT), MODE_FIXED/MODE_RR constants, and the clog2 helper.
//   - Sub-module prio_enc_n (N, W): combinational N-to-W priority encoder with an any-bit output.
//   - Fixed mode uses one prio_enc_n instance. Round-robin uses two instances, masked (>= ptr) and unmasked.
//     The masked result is preferred when its any-bit is set.
//   - The top level holds the FSM, rr pointer, hold counter and output registers.
// TESTING
//   1. Reset in GRANT: with MODE=0, N=4, x=4'b1010 held, assert rst -> the next edge gives valid=0, gnt=0, y=0.
//   2. Fixed priority: x=4'b0110 -> after 1 clk, y=2, gnt=4'b0100, valid=1.
//      Raise x[3] while x[2] is held -> no change. Drop x[2] -> same edge y=3, valid stays 1.
//   3. Round-robin fairness: MODE=1, x=4'b1111 with each winner dropping its request for one cycle after its grant.
//      Required grant order: 0,1,2,3,0.
//      Also: ptr=3 with x=4'b0011 -> y=0 (wrap).
//   4. Idle/no-request: x=0 from reset for 10 cycles -> valid=0, gnt=0, y=0 throughout.
//      Single pulse x=4'b0001 -> valid high for exactly 1 cycle starting 1 clk later.
//   5. Timeout: MAX_HOLD=3, MODE=1, x=4'b0011 held -> y=0 for 3 cycles, then y=1 for 3, then y=0.
//      Sole requester x=4'b0100 -> 3 cycles granted, 1 IDLE cycle, then re-granted.
//   6. Width scaling: N=16, MODE=0, x=16'h8001 -> y=15. Drop bit 15 -> y=0 the same edge.
//      Drop bit 0 -> IDLE, valid=0.

Source files
------------

// File: rtl/rr_priority_arbiter_pkg.sv
// Shared definitions for the registered N-request arbiter: FSM encoding, arbitration
// mode constants and a constant-foldable ceil(log2) helper for parameter sizing.
package rr_priority_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter_prio_enc.sv
// Combinational N-to-W priority encoder: reports the highest set index of x and
// whether any bit is set at all.
module prio_enc_n #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] x,
    output logic [W-1:0] y,
    output logic         any
);

    always_comb begin
        y   = '0;
        any = 1'b0;
        // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
        for (int i = 0; i < int'(N); i++) begin
            if (x[i]) begin
                y   = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-request arbiter with fixed-priority or round-robin selection, grant
// hold until release, and an optional forced release after MAX_HOLD cycles.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = clog2(N),
    parameter int unsigned MODE     = MODE_FIXED,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    output logic [N-1:0] gnt,
    output logic [W-1:0] y,
    output logic         valid
);

    localparam int unsigned    HW        = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  y_q, y_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0]  cand;
    logic [W-1:0]  win;
    logic          win_any;
    logic          rearb;
    logic          timeout;

    // The bit being released (normal drop or timeout) never wins its own re-arbitration.
    assign cand = x & ~gnt_q;

    if (MODE == MODE_RR) begin : g_rr
        logic [N-1:0] above, masked, rev_m, rev_u;
        logic [W-1:0] idx_m, idx_u;
        logic         any_m, any_u;

        // Lowest-index-first is obtained by reversing the vector into a highest-first encoder.
        always_comb begin
            above  = '0;
            rev_m  = '0;
            rev_u  = '0;
            for (int i = 0; i < int'(N); i++) begin
                above[i] = (i >= int'(ptr_q));
            end
            masked = cand & above;
            for (int i = 0; i < int'(N); i++) begin
                rev_m[i] = masked[int'(N) - 1 - i];
                rev_u[i] = cand[int'(N) - 1 - i];
            end
        end

        prio_enc_n #(.N(N), .W(W)) u_enc_masked (
            .x   (rev_m),
            .y   (idx_m),
            .any (any_m)
        );

        prio_enc_n #(.N(N), .W(W)) u_enc_unmasked (
            .x   (rev_u),
            .y   (idx_u),
            .any (any_u)
        );

        assign win     = any_m ? (W'(N - 1) - idx_m) : (W'(N - 1) - idx_u);
        assign win_any = any_u;
    end else begin : g_fixed
        prio_enc_n #(.N(N), .W(W)) u_enc (
            .x   (cand),
            .y   (win),
            .any (win_any)
        );
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        y_d     = y_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        rearb   = 1'b0;
        timeout = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

        unique case (state_q)
            StIdle: begin
                rearb = win_any;
            end
            StGrant: begin
                if (!x[y_q] || timeout) begin
                    rearb = 1'b1;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rearb) begin
            if (win_any) begin
                state_d = StGrant;
                gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
                y_d     = win;
                valid_d = 1'b1;
                hold_d  = '0;
                ptr_d   = (win == W'(N - 1)) ? '0 : win + 1'b1;
            end else begin
                // y keeps its last value on the way back to idle.
                state_d = StIdle;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt   = gnt_q;
    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter: four configurations driven by directed
// vectors, expected outputs queued per cycle and checked by an independent monitor.
module tb_rr_priority_arbiter;

    logic clk;
    logic rst;
    int   cyc;

    logic [3:0]  x_fix, x_rr, x_to;
    logic [15:0] x_w16;
    logic [3:0]  gnt_fix, gnt_rr, gnt_to;
    logic [15:0] gnt_w16;
    logic [1:0]  y_fix, y_rr, y_to;
    logic [3:0]  y_w16;
    logic        valid_fix, valid_rr, valid_to, valid_w16;

    typedef struct {
        int          cyc;
        int          dut;
        logic        v;
        logic [15:0] g;
        logic [3:0]  y;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    rr_priority_arbiter #(.N(4), .MODE(0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .rst(rst), .x(x_fix), .gnt(gnt_fix), .y(y_fix), .valid(valid_fix)
    );
    rr_priority_arbiter #(.N(4), .MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst(rst), .x(x_rr), .gnt(gnt_rr), .y(y_rr), .valid(valid_rr)
    );
    rr_priority_arbiter #(.N(4), .MODE(1), .MAX_HOLD(3)) u_to (
        .clk(clk), .rst(rst), .x(x_to), .gnt(gnt_to), .y(y_to), .valid(valid_to)
    );
    rr_priority_arbiter #(.N(16), .MODE(0), .MAX_HOLD(0)) u_w16 (
        .clk(clk), .rst(rst), .x(x_w16), .gnt(gnt_w16), .y(y_w16), .valid(valid_w16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic tick(input int d, input logic r, input logic [15:0] xv, input logic ev,
                        input logic [15:0] eg, input logic [3:0] ey, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        case (d)
            0:       x_fix = xv[3:0];
            1:       x_rr  = xv[3:0];
            2:       x_to  = xv[3:0];
            default: x_w16 = xv;
        endcase
        e.cyc = cyc + 1;
        e.dut = d;
        e.v   = ev;
        e.g   = eg;
        e.y   = ey;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t        e;
        logic        av;
        logic [15:0] ag;
        logic [3:0]  ay;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin av = valid_fix; ag = {12'b0, gnt_fix}; ay = {2'b0, y_fix}; end
                1:       begin av = valid_rr;  ag = {12'b0, gnt_rr};  ay = {2'b0, y_rr};  end
                2:       begin av = valid_to;  ag = {12'b0, gnt_to};  ay = {2'b0, y_to};  end
                default: begin av = valid_w16; ag = gnt_w16;          ay = y_w16;         end
            endcase
            n_checks++;
            if (e.cyc == cyc && av === e.v && ag === e.g && ay === e.y) begin
                n_pass++;
            end else begin
                $display("FAIL %s (cycle %0d): got valid=%b gnt=%h y=%0d, required valid=%b gnt=%h y=%0d",
                         e.nm, cyc, av, ag, ay, e.v, e.g, e.y);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        x_fix    = '0;
        x_rr     = '0;
        x_to     = '0;
        x_w16    = '0;

        // Idle from reset, then a single-cycle pulse
        tick(0, 1, 16'h0, 0, 16'h0, 4'd0, "reset");
        for (int i = 0; i < 10; i++) tick(0, 0, 16'h0, 0, 16'h0, 4'd0, "idle_no_req");
        tick(0, 0, 16'h1, 1, 16'h1, 4'd0, "pulse_grant");
        tick(0, 0, 16'h0, 0, 16'h0, 4'd0, "pulse_release");
        tick(0, 0, 16'h0, 0, 16'h0, 4'd0, "pulse_idle");

        // Reset mid-grant
        tick(0, 0, 16'hA, 1, 16'h8, 4'd3, "fix_1010");
        tick(0, 1, 16'hA, 0, 16'h0, 4'd0, "rst_mid_grant");
        tick(0, 0, 16'h0, 0, 16'h0, 4'd0, "after_rst");

        // Fixed priority: hold, no preemption, same-edge handover, y kept in idle
        tick(0, 0, 16'h6, 1, 16'h4, 4'd2, "fix_0110");
        tick(0, 0, 16'hE, 1, 16'h4, 4'd2, "fix_no_preempt");
        tick(0, 0, 16'hA, 1, 16'h8, 4'd3, "fix_handover");
        tick(0, 0, 16'h0, 0, 16'h0, 4'd3, "fix_idle_y_held");

        // Round-robin fairness 0,1,2,3,0
        tick(1, 1, 16'h0, 0, 16'h0, 4'd0, "rr_reset");
        tick(1, 0, 16'hF, 1, 16'h1, 4'd0, "rr_grant0");
        tick(1, 0, 16'hE, 1, 16'h2, 4'd1, "rr_grant1");
        tick(1, 0, 16'hD, 1, 16'h4, 4'd2, "rr_grant2");
        tick(1, 0, 16'hB, 1, 16'h8, 4'd3, "rr_grant3");
        tick(1, 0, 16'h7, 1, 16'h1, 4'd0, "rr_grant0_again");

        // Round-robin wrap with ptr=3
        tick(1, 1, 16'h0, 0, 16'h0, 4'd0, "rr_reset2");
        tick(1, 0, 16'h4, 1, 16'h4, 4'd2, "rr_set_ptr3");
        tick(1, 0, 16'h3, 1, 16'h1, 4'd0, "rr_wrap");

        // Timeout with two requesters
        tick(2, 1, 16'h0, 0, 16'h0, 4'd0, "to_reset");
        for (int i = 0; i < 3; i++) tick(2, 0, 16'h3, 1, 16'h1, 4'd0, "to_hold0");
        for (int i = 0; i < 3; i++) tick(2, 0, 16'h3, 1, 16'h2, 4'd1, "to_hold1");
        tick(2, 0, 16'h3, 1, 16'h1, 4'd0, "to_back0");

        // Timeout with a sole requester: one idle cycle then re-grant
        tick(2, 1, 16'h0, 0, 16'h0, 4'd0, "to_reset2");
        for (int i = 0; i < 3; i++) tick(2, 0, 16'h4, 1, 16'h4, 4'd2, "to_sole_hold");
        tick(2, 0, 16'h4, 0, 16'h0, 4'd2, "to_sole_idle");
        tick(2, 0, 16'h4, 1, 16'h4, 4'd2, "to_sole_regrant");

        // Width scaling, N=16
        tick(3, 1, 16'h0000, 0, 16'h0000, 4'd0,  "w16_reset");
        tick(3, 0, 16'h8001, 1, 16'h8000, 4'd15, "w16_y15");
        tick(3, 0, 16'h0001, 1, 16'h0001, 4'd0,  "w16_handover0");
        tick(3, 0, 16'h8001, 1, 16'h0001, 4'd0,  "w16_no_preempt");
        tick(3, 0, 16'h8000, 1, 16'h8000, 4'd15, "w16_handover15");
        tick(3, 0, 16'h0000, 0, 16'h0000, 4'd15, "w16_idle");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
